// File: rtl/riscv_hwloop_regfile.sv
// Hardware-loop register file: per-set start/end addresses and loop counters.
// Software writes any mix of fields of one set per cycle. The pipeline
// decrements counters with a one-hot request. A multi-hot request is rejected
// and flagged with a one-cycle error pulse.
module riscv_hwloop_regfile #(
  parameter  int N_REGSETS = 2,
  parameter  int CNT_WIDTH = 32,
  localparam int RID_W     = (N_REGSETS > 1) ? $clog2(N_REGSETS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [31:0]                    hwlp_start_data_i,
  input  logic [31:0]                    hwlp_end_data_i,
  input  logic [CNT_WIDTH-1:0]           hwlp_cnt_data_i,
  input  logic [2:0]                     hwlp_we_i,
  input  logic [RID_W-1:0]               hwlp_regid_i,
  input  logic                           valid_i,
  input  logic [N_REGSETS-1:0]           hwlp_dec_cnt_i,
  output logic [N_REGSETS*32-1:0]        hwlp_start_addr_o,
  output logic [N_REGSETS*32-1:0]        hwlp_end_addr_o,
  output logic [N_REGSETS*CNT_WIDTH-1:0] hwlp_counter_o,
  output logic [N_REGSETS-1:0]           hwlp_active_o,
  output logic [N_REGSETS-1:0]           hwlp_last_o,
  output logic                           hwlp_dec_err_o
);

  localparam logic [N_REGSETS-1:0] L_DEC_ONE = N_REGSETS'(1);
  localparam logic [CNT_WIDTH-1:0] L_CNT_ONE = CNT_WIDTH'(1);

  logic w_regid_ok;
  logic w_dec_multi;
  logic w_dec_single;
  logic r_dec_err;

  // Writes naming a set that does not exist are dropped entirely.
  assign w_regid_ok = ({{(32-RID_W){1'b0}}, hwlp_regid_i} < 32'(N_REGSETS));

  // x & (x-1) is nonzero exactly when two or more request bits are set.
  assign w_dec_multi  = |(hwlp_dec_cnt_i & (hwlp_dec_cnt_i - L_DEC_ONE));
  assign w_dec_single = valid_i & (|hwlp_dec_cnt_i) & ~w_dec_multi;

  for (genvar k = 0; k < N_REGSETS; k++) begin : g_set
    logic [31:0]          r_start;
    logic [31:0]          r_end;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_sel;

    assign w_sel = w_regid_ok && (hwlp_regid_i == RID_W'(k));

    // Per-set state. A counter write beats a same-set decrement, and the
    // decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_start <= '0;
        r_end   <= '0;
        r_cnt   <= '0;
      end else begin
        if (w_sel && hwlp_we_i[0]) r_start <= {hwlp_start_data_i[31:1], 1'b0};
        if (w_sel && hwlp_we_i[1]) r_end   <= {hwlp_end_data_i[31:1], 1'b0};
        if (w_sel && hwlp_we_i[2]) begin
          r_cnt <= hwlp_cnt_data_i;
        end else if (w_dec_single && hwlp_dec_cnt_i[k] && (r_cnt != '0)) begin
          r_cnt <= r_cnt - L_CNT_ONE;
        end
      end
    end

    assign hwlp_start_addr_o[k*32 +: 32]             = r_start;
    assign hwlp_end_addr_o[k*32 +: 32]               = r_end;
    assign hwlp_counter_o[k*CNT_WIDTH +: CNT_WIDTH]  = r_cnt;
    assign hwlp_active_o[k]                          = (r_cnt != '0);
    assign hwlp_last_o[k]                            = (r_cnt == L_CNT_ONE);
  end

  // Error pulse: high for the one cycle after a qualified multi-hot request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dec_err <= 1'b0;
    else        r_dec_err <= valid_i & w_dec_multi;
  end

  assign hwlp_dec_err_o = r_dec_err;

endmodule

// File: tb/tb_riscv_hwloop_regfile.sv
// Self-checking bench for riscv_hwloop_regfile: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a behavioural model.
module tb_riscv_hwloop_regfile;

  localparam int N  = 3;
  localparam int CW = 16;
  localparam int RW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     startD, endD;
  logic [CW-1:0]   cntD;
  logic [2:0]      we;
  logic [RW-1:0]   regid;
  logic            valid;
  logic [N-1:0]    dec;
  logic [N*32-1:0] startO, endO;
  logic [N*CW-1:0] cntO;
  logic [N-1:0]    activeO, lastO;
  logic            errO;

  int nChecks = 0;
  int nFails  = 0;
  bit checkEn = 1'b0;

  // reference model state
  logic [31:0]   mStart [N] = '{default: '0};
  logic [31:0]   mEnd   [N] = '{default: '0};
  logic [CW-1:0] mCnt   [N] = '{default: '0};
  logic          mErr       = 1'b0;

  riscv_hwloop_regfile #(.N_REGSETS(N), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .hwlp_start_data_i(startD), .hwlp_end_data_i(endD), .hwlp_cnt_data_i(cntD),
    .hwlp_we_i(we), .hwlp_regid_i(regid), .valid_i(valid), .hwlp_dec_cnt_i(dec),
    .hwlp_start_addr_o(startO), .hwlp_end_addr_o(endO), .hwlp_counter_o(cntO),
    .hwlp_active_o(activeO), .hwlp_last_o(lastO), .hwlp_dec_err_o(errO)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain rules applied once per clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        mStart[k] = '0; mEnd[k] = '0; mCnt[k] = '0;
      end
      mErr = 1'b0;
    end else begin
      int ones;
      ones = $countones(dec);
      for (int k = 0; k < N; k++) begin
        bit hit;
        hit = (int'(regid) == k);
        if (hit && we[0]) mStart[k] = startD & 32'hFFFF_FFFE;
        if (hit && we[1]) mEnd[k]   = endD & 32'hFFFF_FFFE;
        if (hit && we[2]) mCnt[k] = cntD;
        else if (valid && ones == 1 && dec[k] && mCnt[k] > 0) mCnt[k] = mCnt[k] - 1'b1;
      end
      mErr = valid && (ones >= 2);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int k = 0; k < N; k++) begin
        checkOutput($sformatf("model_start[%0d]", k), 64'(startO[k*32 +: 32]), 64'(mStart[k]));
        checkOutput($sformatf("model_end[%0d]", k), 64'(endO[k*32 +: 32]), 64'(mEnd[k]));
        checkOutput($sformatf("model_cnt[%0d]", k), 64'(cntO[k*CW +: CW]), 64'(mCnt[k]));
        checkOutput($sformatf("model_active[%0d]", k), 64'(activeO[k]), 64'(mCnt[k] != 0));
        checkOutput($sformatf("model_last[%0d]", k), 64'(lastO[k]), 64'(mCnt[k] == 1));
      end
      checkOutput("model_err", 64'(errO), 64'(mErr));
    end
  end

  task automatic idleInputs();
    we = 3'b000; regid = '0; startD = '0; endD = '0; cntD = '0; valid = 1'b0; dec = '0;
  endtask

  // Drive one cycle of inputs, let the edge happen, leave outputs settled.
  task automatic applyStimulus(input logic [2:0] w, input logic [RW-1:0] rid,
                               input logic [31:0] s, input logic [31:0] e,
                               input logic [CW-1:0] c, input logic v, input logic [N-1:0] d);
    we = w; regid = rid; startD = s; endD = e; cntD = c; valid = v; dec = d;
    @(posedge clk);
    #1;
    idleInputs();
  endtask

  function automatic logic [CW-1:0] cntOf(input int k);
    return cntO[k*CW +: CW];
  endfunction

  initial begin
    idleInputs();
    rst_n = 1'b0;
    #1;
    checkOutput("reset_cnt", 64'(cntO), 64'h0);
    checkOutput("reset_active", 64'(activeO), 64'h0);
    checkOutput("reset_last", 64'(lastO), 64'h0);
    checkOutput("reset_err", 64'(errO), 64'h0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    checkEn = 1'b1;

    // write all three fields of set 1
    applyStimulus(3'b111, 2'd1, 32'h1003, 32'h1020, 16'd3, 1'b0, 3'b000);
    checkOutput("wr_start1", 64'(startO[63:32]), 64'h1002);
    checkOutput("wr_end1", 64'(endO[63:32]), 64'h1020);
    checkOutput("wr_cnt1", 64'(cntOf(1)), 64'd3);
    checkOutput("wr_active", 64'(activeO), 64'b010);
    checkOutput("wr_set0_start", 64'(startO[31:0]), 64'h0);
    checkOutput("wr_set0_cnt", 64'(cntOf(0)), 64'h0);

    // decrement set 0 down through zero
    applyStimulus(3'b100, 2'd0, 32'h0, 32'h0, 16'd2, 1'b0, 3'b000);
    applyStimulus(3'b000, 2'd0, 32'h0, 32'h0, 16'd0, 1'b1, 3'b001);
    checkOutput("dec_cnt0_1", 64'(cntOf(0)), 64'd1);
    checkOutput("dec_last0", 64'(lastO[0]), 64'd1);
    applyStimulus(3'b000, 2'd0, 32'h0, 32'h0, 16'd0, 1'b1, 3'b001);
    checkOutput("dec_cnt0_0", 64'(cntOf(0)), 64'd0);
    checkOutput("dec_active0", 64'(activeO[0]), 64'd0);
    applyStimulus(3'b000, 2'd0, 32'h0, 32'h0, 16'd0, 1'b1, 3'b001);
    checkOutput("dec_saturate", 64'(cntOf(0)), 64'd0);

    // write/decrement priority
    applyStimulus(3'b100, 2'd0, 32'h0, 32'h0, 16'd5, 1'b0, 3'b000);
    applyStimulus(3'b100, 2'd1, 32'h0, 32'h0, 16'd7, 1'b0, 3'b000);
    applyStimulus(3'b100, 2'd0, 32'h0, 32'h0, 16'd9, 1'b1, 3'b001);
    checkOutput("prio_write_wins", 64'(cntOf(0)), 64'd9);
    applyStimulus(3'b000, 2'd0, 32'h0, 32'h0, 16'd0, 1'b1, 3'b010);
    checkOutput("prio_dec_set1", 64'(cntOf(1)), 64'd6);
    applyStimulus(3'b100, 2'd1, 32'h0, 32'h0, 16'd4, 1'b1, 3'b001);
    checkOutput("prio_cross_wr", 64'(cntOf(1)), 64'd4);
    checkOutput("prio_cross_dec", 64'(cntOf(0)), 64'd8);

    // multi-hot decrement request
    applyStimulus(3'b100, 2'd0, 32'h0, 32'h0, 16'd5, 1'b0, 3'b000);
    applyStimulus(3'b100, 2'd1, 32'h0, 32'h0, 16'd7, 1'b0, 3'b000);
    applyStimulus(3'b000, 2'd0, 32'h0, 32'h0, 16'd0, 1'b1, 3'b011);
    checkOutput("multi_cnt0", 64'(cntOf(0)), 64'd5);
    checkOutput("multi_cnt1", 64'(cntOf(1)), 64'd7);
    checkOutput("multi_err_hi", 64'(errO), 64'd1);
    applyStimulus(3'b000, 2'd0, 32'h0, 32'h0, 16'd0, 1'b0, 3'b011);
    checkOutput("multi_err_lo", 64'(errO), 64'd0);
    checkOutput("novalid_cnt0", 64'(cntOf(0)), 64'd5);
    checkOutput("novalid_cnt1", 64'(cntOf(1)), 64'd7);

    // out-of-range regid, then set 2
    applyStimulus(3'b111, 2'd3, 32'hABCD, 32'hBEEF, 16'h55, 1'b0, 3'b000);
    checkOutput("badid_cnt", 64'(cntO), {16'h0, 16'd0, 16'd7, 16'd5});
    checkOutput("badid_start2", 64'(startO[95:64]), 64'h0);
    applyStimulus(3'b100, 2'd2, 32'h0, 32'h0, 16'h10, 1'b0, 3'b000);
    checkOutput("set2_cnt", 64'(cntOf(2)), 64'h10);

    // async reset between edges with a write pending
    @(negedge clk);
    we = 3'b100; regid = 2'd2; cntD = 16'h33;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_cnt", 64'(cntO), 64'h0);
    checkOutput("async_active", 64'(activeO), 64'h0);
    checkOutput("async_start", 64'(startO), 64'h0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    idleInputs();
    checkOutput("post_reset_wr", 64'(cntOf(2)), 64'h33);
    checkOutput("post_reset_cnt0", 64'(cntOf(0)), 64'h0);

    // randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 500; i++) begin
      logic [2:0]    rw;
      logic [N-1:0]  rd;
      logic [CW-1:0] rc;
      int sel;
      rw = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) rw = 3'b000;
      sel = $urandom_range(0, 3);
      rd = (sel == 0) ? 3'b000 : (sel == 3) ? 3'($urandom_range(0, 7)) : 3'(1 << $urandom_range(0, 2));
      rc = ($urandom_range(0, 3) == 0) ? CW'($urandom) : CW'($urandom_range(0, 4));
      if ($urandom_range(0, 60) == 0) begin
        @(negedge clk); #2 rst_n = 1'b0; #2 rst_n = 1'b1;
      end
      applyStimulus(rw, 2'($urandom_range(0, 3)), $urandom, $urandom, rc,
                    1'($urandom_range(0, 1)), rd);
    end

    @(posedge clk); #1;
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
